// File: rtl/count_arbiter.sv
// count_arbiter
//
// Round-robin controller that lends one shared 8-bit up-counter to two
// requesters. For each granted run it clears the counter for one cycle, then
// triggers it until it reaches the winner's latched target, and finally
// pulses `done` to the winner. A run can be cancelled by `abort` or by the
// owner dropping its request; a cancelled run returns to idle without `done`.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   req          in   [1:0] request level per requester
//   target0      in   [WIDTH-1:0] stop value for requester 0, latched at grant
//   target1      in   [WIDTH-1:0] stop value for requester 1, latched at grant
//   abort        in   synchronous cancel of the current run
//   grant        out  [1:0] one-hot owner of the counter, 0 when idle
//   done         out  [1:0] one-cycle completion pulse to the owner
//   busy         out  high whenever the controller is not idle
//   ctr_clear    out  synchronous clear to the counter
//   ctr_trigger  out  increment enable to the counter (combinational)
//   ctr_count    in   [WIDTH-1:0] current counter value

module count_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] target0,
  input  logic [WIDTH-1:0] target1,
  input  logic             abort,
  output logic [1:0]       grant,
  output logic [1:0]       done,
  output logic             busy,
  output logic             ctr_clear,
  output logic             ctr_trigger,
  input  logic [WIDTH-1:0] ctr_count
);

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StRun,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] tgt_q;
  logic             last_q;     // index of the most recent winner
  logic [1:0]       grant_q;
  logic [1:0]       done_q;
  logic             busy_q;
  logic             ctr_clear_q;

  logic             winner;
  logic             owner_req;
  logic             active;
  logic             cancel;
  logic             cnt_hit;

  // Winner selection: a lone requester wins outright; on contention the
  // requester that did not win last time gets the counter.
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      default: winner = ~last_q;
    endcase
  end

  // The owner is still asking if its request bit overlaps the one-hot grant.
  assign owner_req = |(req & grant_q);
  assign active    = (state_q == StClear) || (state_q == StRun);
  // Cancellation takes priority over reaching the target in the same cycle.
  assign cancel    = active && (abort || !owner_req);
  assign cnt_hit   = (ctr_count == tgt_q);

  // The only combinational output: stop triggering as soon as the target is
  // reached, and never trigger in a cycle that is being cancelled so the
  // counter holds its value.
  assign ctr_trigger = (state_q == StRun) && !cancel && !cnt_hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      tgt_q       <= '0;
      last_q      <= 1'b1;
      grant_q     <= 2'b00;
      done_q      <= 2'b00;
      busy_q      <= 1'b0;
      ctr_clear_q <= 1'b0;
    end else begin
      done_q      <= 2'b00;
      ctr_clear_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            state_q     <= StClear;
            tgt_q       <= winner ? target1 : target0;
            grant_q     <= winner ? 2'b10 : 2'b01;
            last_q      <= winner;
            busy_q      <= 1'b1;
            ctr_clear_q <= 1'b1;
          end
        end
        StClear: begin
          if (cancel) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
          end else begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (cancel) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
          end else if (cnt_hit) begin
            state_q <= StDone;
            done_q  <= grant_q;
          end
        end
        StDone: begin
          state_q <= StIdle;
          grant_q <= 2'b00;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          grant_q <= 2'b00;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign ctr_clear = ctr_clear_q;

endmodule

// File: tb/tb_count_arbiter.sv
// Self-checking bench for count_arbiter. Provides a behavioural model of the
// shared counter, drives directed and randomized runs, and predicts winner,
// latency, trigger count and final count from the arbitration rules.
module tb_count_arbiter;

  logic       clock;
  logic       reset;
  logic [1:0] req;
  logic [7:0] target0;
  logic [7:0] target1;
  logic       abort;
  logic [1:0] grant;
  logic [1:0] done;
  logic       busy;
  logic       ctr_clear;
  logic       ctr_trigger;
  logic [7:0] cnt;

  int tests = 0;
  int fails = 0;
  int last_m = 1;  // model: index of last winner, requester 0 wins first tie

  count_arbiter #(.WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .target0    (target0),
    .target1    (target1),
    .abort      (abort),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .ctr_clear  (ctr_clear),
    .ctr_trigger(ctr_trigger),
    .ctr_count  (cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shared counter: synchronous clear, increment on trigger.
  always @(posedge clock) begin
    if (ctr_clear) cnt <= 8'd0;
    else if (ctr_trigger) cnt <= cnt + 8'd1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    if (obs != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Entered at the negedge of an idle cycle (cycle 0); returns at the negedge
  // of the idle cycle following the run. mode 0: complete, 1: abort,
  // 2: owner drops req, when the count equals stop_at % N. new_t >= 0
  // rewrites the owner's target after grant.
  task automatic run_txn(input logic [1:0] r, input int t0, input int t1,
                         input int mode_in, input int stop_in, input int new_t);
    int win, n, mode, stop_at, trig, done_c, bad_grant, done_any, cut;
    logic [1:0] eg;
    logic [1:0] done_v;
    req = r; target0 = 8'(t0); target1 = 8'(t1); abort = 1'b0;
    if (r == 2'b01) win = 0;
    else if (r == 2'b10) win = 1;
    else win = (last_m == 0) ? 1 : 0;
    last_m = win;
    n  = win ? t1 : t0;
    eg = win ? 2'b10 : 2'b01;
    mode = (n == 0) ? 0 : mode_in;
    stop_at = (n == 0) ? 0 : stop_in % n;
    trig = 0; done_c = -1; done_v = 2'b00; bad_grant = 0; done_any = 0; cut = 0;

    @(negedge clock);  // cycle 1: CLEAR
    check("clr_grant", grant, eg);
    check("clr_pulse", ctr_clear, 1);
    check("clr_busy", busy, 1);

    for (int c = 2; c <= n + 4; c++) begin
      @(negedge clock);
      if (c == 2) check("run_start", cnt, 0);
      if (ctr_trigger) trig++;
      if (done != 2'b00) done_any++;
      if (done != 2'b00 && done_c < 0) begin done_c = c; done_v = done; end
      if (c <= n + 3 && grant != eg) bad_grant++;
      if (mode != 0 && cnt == 8'(stop_at)) begin
        if (mode == 1) abort = 1'b1;
        else req[win] = 1'b0;
        #1;
        check("cut_trig", ctr_trigger, 0);
        cut = 1;
        @(negedge clock);
        abort = 1'b0;
        if (done != 2'b00) done_any++;
        check("cut_busy", busy, 0);
        check("cut_grant", grant, 0);
        check("cut_hold", cnt, stop_at);
        break;
      end
      if (c == 2 && new_t >= 0) begin
        if (win == 1) target1 = 8'(new_t);
        else target0 = 8'(new_t);
      end
    end

    if (mode != 0) begin
      check("cut_seen", cut, 1);
      check("cut_nodone", done_any, 0);
    end else begin
      check("done_cycle", done_c, n + 3);
      check("done_val", done_v, eg);
      check("done_once", done_any, 1);
      check("trig_cycles", trig, n);
      check("grant_stable", bad_grant, 0);
      check("end_busy", busy, 0);
      check("end_grant", grant, 0);
      check("end_count", cnt, n);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; req = 2'b00; abort = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    last_m = 1;
    @(negedge clock);
  endtask

  initial begin
    int held;
    reset = 1'b0; req = 2'b00; target0 = 8'd0; target1 = 8'd0; abort = 1'b0;
    repeat (20) @(negedge clock);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_clear", ctr_clear, 0);
    check("rst_trig", ctr_trigger, 0);
    reset = 1'b1;
    @(negedge clock);

    // Single run, then abort in idle is ignored.
    run_txn(2'b01, 5, 0, 0, 0, -1);
    req = 2'b00; abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("idle_abort", busy, 0);

    // Contention and fairness from a fresh reset.
    do_reset();
    for (int i = 0; i < 6; i++) run_txn(2'b11, 3, 2, 0, 0, -1);

    // Boundaries.
    run_txn(2'b10, 0, 0, 0, 0, -1);
    run_txn(2'b01, 255, 0, 0, 0, -1);

    // Abort at count 4, then a clean restart from 0.
    run_txn(2'b01, 10, 0, 1, 4, -1);
    run_txn(2'b01, 7, 0, 0, 0, -1);

    // Late target change ignored, owner drops at count 3.
    run_txn(2'b10, 0, 6, 2, 3, 2);

    // Asynchronous reset between edges during RUN.
    req = 2'b01; target0 = 8'd50; last_m = 0;
    repeat (6) @(negedge clock);
    check("pre_rst_trig", ctr_trigger, 1);
    check("pre_rst_cnt", cnt, 4);
    held = int'(cnt);
    #2 reset = 1'b0;
    #1;
    check("async_grant", grant, 0);
    check("async_busy", busy, 0);
    check("async_trig", ctr_trigger, 0);
    req = 2'b11;
    repeat (3) @(negedge clock);
    check("rst_cnt_hold", cnt, held);
    reset = 1'b1;
    last_m = 1;
    run_txn(2'b11, 4, 4, 0, 0, -1);

    // Randomized runs.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] r;
      int nt;
      r  = 2'($urandom_range(1, 3));
      nt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      run_txn(r, int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 255)), nt);
      if ($urandom_range(0, 3) == 0) begin
        req = 2'b00;
        repeat ($urandom_range(1, 3)) @(negedge clock);
        check("gap_idle", busy, 0);
      end
    end

    req = 2'b00;
    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "time limit");
  end

endmodule
